// File: rtl/kappa3_exec_ctrl_if.sv
// kappa3_exec_ctrl_if
//   Bundles the debugger-button requests, the core status the sequencer
//   observes and the control/status it returns.
//   master : debugger/core side (drives buttons, cstate, pc, breakpoint, halt)
//   slave  : execution sequencer (drives core_en, running, bp_hit, inst_count)
//   Signals:
//     btn_run/btn_phase/btn_inst  level button requests, already synchronised
//     cstate      one-hot core phase [0]=F [1]=DE [2]=EX [3]=WB
//     pc          core PC, meaningful while cstate[0]
//     bp_en/bp_addr  PC breakpoint enable and address
//     halt_req    core has decoded a halt instruction
//     core_en     one-phase advance enable to the core
//     running     sequencer is not idle
//     bp_hit      sticky "stopped on breakpoint" flag
//     inst_count  retired-instruction counter (wraps)
interface kappa3_exec_ctrl_if #(
    parameter int CW   = 32,
    parameter int PC_W = 32
);
    logic            btn_run;
    logic            btn_phase;
    logic            btn_inst;
    logic [3:0]      cstate;
    logic [PC_W-1:0] pc;
    logic            bp_en;
    logic [PC_W-1:0] bp_addr;
    logic            halt_req;
    logic            core_en;
    logic            running;
    logic            bp_hit;
    logic [CW-1:0]   inst_count;

    modport master (
        output btn_run, btn_phase, btn_inst, cstate, pc, bp_en, bp_addr, halt_req,
        input  core_en, running, bp_hit, inst_count
    );

    modport slave (
        input  btn_run, btn_phase, btn_inst, cstate, pc, bp_en, bp_addr, halt_req,
        output core_en, running, bp_hit, inst_count
    );
endinterface

// File: rtl/kappa3_exec_ctrl.sv
// kappa3_exec_ctrl
//   Execution sequencer for the KAPPA3-LIGHT core. Converts run/stop,
//   step-phase and step-instruction button presses into a per-cycle phase
//   enable, stops on a PC breakpoint or a halt request, and counts retired
//   instructions.
//   Ports:
//     clock  CPU-side clock, all state changes on its rising edge
//     reset  asynchronous, active-low reset
//     bus    kappa3_exec_ctrl_if.slave (buttons, core status, core_en,
//            running, bp_hit, inst_count)
module kappa3_exec_ctrl #(
    parameter int CW   = 32,
    parameter int PC_W = 32
) (
    input  logic                clock,
    input  logic                reset,
    kappa3_exec_ctrl_if.slave   bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PHASE = 2'd2;
    localparam logic [1:0] INST  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          runHist_q, phaseHist_q, instHist_q;
    logic          skipBp_q, skipBp_d;
    logic          bpHit_q, bpHit_d;
    logic          running_q;
    logic [CW-1:0] instCount_q, instCount_d;

    logic pressRun, pressPhase, pressInst;
    logic atFetch, atWriteBack, bpMatch;
    logic coreEn;

    // A press is the rising level of a button. History regs reset to 1 so a
    // button held through reset is not seen as a fresh press.
    assign pressRun   = bus.btn_run   & ~runHist_q;
    assign pressPhase = bus.btn_phase & ~phaseHist_q;
    assign pressInst  = bus.btn_inst  & ~instHist_q;

    // Phase decodes require a clean one-hot cstate; a corrupted phase neither
    // retires an instruction nor matches the breakpoint.
    assign atFetch     = (bus.cstate == 4'b0001);
    assign atWriteBack = (bus.cstate == 4'b1000);

    // skip_bp masks the breakpoint at the PC we resumed from, so a restart
    // from a breakpoint executes that instruction instead of re-hitting it.
    assign bpMatch = atFetch & bus.bp_en & (bus.pc == bus.bp_addr) & ~skipBp_q;

    // Next-state and core enable. Every stop source forces core_en low in the
    // same cycle it is seen, so the core never advances past a stop point.
    always_comb begin
        state_d  = state_q;
        skipBp_d = skipBp_q;
        bpHit_d  = bpHit_q;
        coreEn   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.halt_req) begin
                    if (pressRun) begin
                        state_d  = RUN;
                        skipBp_d = 1'b1;
                        bpHit_d  = 1'b0;
                    end else if (pressInst) begin
                        state_d = INST;
                        bpHit_d = 1'b0;
                    end else if (pressPhase) begin
                        state_d = PHASE;
                        bpHit_d = 1'b0;
                    end
                end
            end
            PHASE: begin
                coreEn  = ~bus.halt_req;
                state_d = IDLE;
            end
            INST: begin
                if (pressRun || bus.halt_req) begin
                    state_d = IDLE;
                end else begin
                    coreEn = 1'b1;
                    // The WB cycle is still enabled so the core lands on F.
                    if (atWriteBack) begin
                        state_d = IDLE;
                    end
                end
            end
            RUN: begin
                coreEn = ~(bpMatch | pressRun | bus.halt_req);
                if (!coreEn) begin
                    state_d = IDLE;
                end else begin
                    skipBp_d = 1'b0;
                end
                if (bpMatch) begin
                    bpHit_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        instCount_d = instCount_q;
        if (coreEn && atWriteBack) begin
            instCount_d = instCount_q + CW'(1);
        end
    end

    // State, button history and status registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            runHist_q   <= 1'b1;
            phaseHist_q <= 1'b1;
            instHist_q  <= 1'b1;
            skipBp_q    <= 1'b0;
            bpHit_q     <= 1'b0;
            running_q   <= 1'b0;
            instCount_q <= '0;
        end else begin
            state_q     <= state_d;
            runHist_q   <= bus.btn_run;
            phaseHist_q <= bus.btn_phase;
            instHist_q  <= bus.btn_inst;
            skipBp_q    <= skipBp_d;
            bpHit_q     <= bpHit_d;
            running_q   <= (state_d != IDLE);
            instCount_q <= instCount_d;
        end
    end

    assign bus.core_en    = coreEn;
    assign bus.running    = running_q;
    assign bus.bp_hit     = bpHit_q;
    assign bus.inst_count = instCount_q;

endmodule
